// File: rtl/datamover_rd_ctrl_if.sv
// datamover_rd_ctrl_if: command, stream and HP0 AXI3 read-channel bundle for datamover_rd_ctrl
// master : the read engine (drives ack/stream/AR/rready, receives cmd/ready/R)
// slave  : the environment (command source, stream consumer and HP0 memory)
interface datamover_rd_ctrl_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 23
);
   logic [ADDR_WIDTH-1:0] i_rd_cmd_addr;
   logic [LEN_WIDTH-1:0]  i_rd_cmd_length;
   logic                  i_rd_cmd_req;
   logic                  o_rd_cmd_ack;
   logic                  i_rd_ready;
   logic                  o_rd_valid;
   logic [DATA_WIDTH-1:0] o_rd_data;
   logic                  o_rd_last;
   logic                  o_read_finish;
   logic                  o_rd_error;
   logic                  hp0_arready;
   logic                  hp0_arvalid;
   logic [3:0]            hp0_arid;
   logic [ADDR_WIDTH-1:0] hp0_araddr;
   logic [3:0]            hp0_arlen;
   logic [2:0]            hp0_arsize;
   logic [1:0]            hp0_arburst;
   logic [2:0]            hp0_arprot;
   logic [3:0]            hp0_arcache;
   logic [DATA_WIDTH-1:0] hp0_rdata;
   logic [1:0]            hp0_rresp;
   logic                  hp0_rlast;
   logic                  hp0_rvalid;
   logic                  hp0_rready;
   modport master (
      input  i_rd_cmd_addr, i_rd_cmd_length, i_rd_cmd_req, i_rd_ready,
             hp0_arready, hp0_rdata, hp0_rresp, hp0_rlast, hp0_rvalid,
      output o_rd_cmd_ack, o_rd_valid, o_rd_data, o_rd_last, o_read_finish, o_rd_error,
             hp0_arvalid, hp0_arid, hp0_araddr, hp0_arlen, hp0_arsize, hp0_arburst,
             hp0_arprot, hp0_arcache, hp0_rready
   );
   modport slave (
      output i_rd_cmd_addr, i_rd_cmd_length, i_rd_cmd_req, i_rd_ready,
             hp0_arready, hp0_rdata, hp0_rresp, hp0_rlast, hp0_rvalid,
      input  o_rd_cmd_ack, o_rd_valid, o_rd_data, o_rd_last, o_read_finish, o_rd_error,
             hp0_arvalid, hp0_arid, hp0_araddr, hp0_arlen, hp0_arsize, hp0_arburst,
             hp0_arprot, hp0_arcache, hp0_rready
   );
endinterface

// File: rtl/datamover_rd_ctrl.sv
// datamover_rd_ctrl: MM2S read engine, splits a command into 4 KB-safe INCR bursts on HP0 and streams R beats out
// clk, rst_n : clock, asynchronous active-low reset
// bus        : command req/ack, output stream (valid/ready/data/last), finish/error, HP0 AR and R channels
module datamover_rd_ctrl #(
   parameter int         DATA_WIDTH = 64,
   parameter int         ADDR_WIDTH = 32,
   parameter int         LEN_WIDTH  = 23,
   parameter logic [3:0] AXI_ID     = 4'h0,
   parameter int         MAX_BURST  = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   datamover_rd_ctrl_if.master bus
);
   localparam int BW = LEN_WIDTH - 3;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q, araddr_q;
   logic [BW-1:0]         rem_q, total_q, cnt_q, lim;
   logic [4:0]            burst_q, burst;
   logic [3:0]            arlen_q;
   logic                  arvalid_q, ack_q, fin_q, err_q, drain_q;
   logic [12:0]           room;
   logic                  rready, push, pop, in_last, head_load;
   logic                  head_v_q, head_v_d, head_l_q, head_l_d, tail_v_q, tail_v_d, tail_l_q, tail_l_d;
   logic [DATA_WIDTH-1:0] head_dat_q, head_dat_d, tail_dat_q, tail_dat_d;
   // bytes left before the next 4 KB page, converted to beats below
   assign room    = 13'h1000 - {1'b0, addr_q[11:0]};
   assign lim     = (rem_q > BW'(MAX_BURST)) ? BW'(MAX_BURST) : rem_q;
   assign burst   = 5'((BW'(room[12:3]) < lim) ? BW'(room[12:3]) : lim);
   // once the final rlast is in, no more R beats are accepted while the buffer drains
   assign rready  = (state_q == DATA) & ~drain_q & ~(head_v_q & tail_v_q);
   assign push    = bus.hp0_rvalid & rready;
   assign pop     = head_v_q & bus.i_rd_ready;
   assign in_last = (cnt_q + BW'(1)) == total_q;
   always_comb begin
      head_load  = ~head_v_q | pop;
      head_v_d   = pop ? (tail_v_q | push) : (head_v_q | push);
      head_dat_d = head_load ? (tail_v_q ? tail_dat_q : bus.hp0_rdata) : head_dat_q;
      head_l_d   = head_load ? (tail_v_q ? tail_l_q : in_last) : head_l_q;
      tail_v_d   = pop ? 1'b0 : (tail_v_q | (push & head_v_q));
      tail_dat_d = (push & head_v_q & ~pop) ? bus.hp0_rdata : tail_dat_q;
      tail_l_d   = (push & head_v_q & ~pop) ? in_last : tail_l_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_v_q   <= 1'b0;
         head_l_q   <= 1'b0;
         head_dat_q <= '0;
         tail_v_q   <= 1'b0;
         tail_l_q   <= 1'b0;
         tail_dat_q <= '0;
      end else begin
         head_v_q   <= head_v_d;
         head_l_q   <= head_l_d;
         head_dat_q <= head_dat_d;
         tail_v_q   <= tail_v_d;
         tail_l_q   <= tail_l_d;
         tail_dat_q <= tail_dat_d;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         araddr_q  <= '0;
         rem_q     <= '0;
         total_q   <= '0;
         cnt_q     <= '0;
         burst_q   <= '0;
         arlen_q   <= '0;
         arvalid_q <= 1'b0;
         ack_q     <= 1'b0;
         fin_q     <= 1'b0;
         err_q     <= 1'b0;
         drain_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         if (push) begin
            cnt_q <= cnt_q + BW'(1);
            if (bus.hp0_rresp != 2'b00) err_q <= 1'b1;
         end
         case (state_q)
            IDLE: if (bus.i_rd_cmd_req) begin
               ack_q   <= 1'b1;
               err_q   <= 1'b0;
               cnt_q   <= '0;
               addr_q  <= bus.i_rd_cmd_addr;
               rem_q   <= bus.i_rd_cmd_length[LEN_WIDTH-1:3];
               total_q <= bus.i_rd_cmd_length[LEN_WIDTH-1:3];
               state_q <= (bus.i_rd_cmd_length[LEN_WIDTH-1:3] == '0) ? DONE : ADDR;
            end
            // first ADDR cycle latches the burst, then AR is held stable until arready
            ADDR: if (!arvalid_q) begin
               arvalid_q <= 1'b1;
               araddr_q  <= addr_q;
               arlen_q   <= 4'(burst - 5'd1);
               burst_q   <= burst;
            end else if (bus.hp0_arready) begin
               arvalid_q <= 1'b0;
               addr_q    <= addr_q + ADDR_WIDTH'({burst_q, 3'b000});
               rem_q     <= rem_q - BW'(burst_q);
               state_q   <= DATA;
            end
            DATA: begin
               if (push & bus.hp0_rlast) begin
                  if (rem_q == '0) drain_q <= 1'b1;
                  else state_q <= ADDR;
               end
               if (drain_q & pop & ~tail_v_q) begin
                  drain_q <= 1'b0;
                  fin_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            // data path enters with fin_q set; a zero-length command enters clear and spends one extra cycle
            DONE: begin
               fin_q <= ~fin_q;
               if (fin_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.o_rd_cmd_ack  = ack_q;
   assign bus.o_rd_valid    = head_v_q;
   assign bus.o_rd_data     = head_dat_q;
   assign bus.o_rd_last     = head_l_q;
   assign bus.o_read_finish = fin_q;
   assign bus.o_rd_error    = err_q;
   assign bus.hp0_arvalid   = arvalid_q;
   assign bus.hp0_arid      = AXI_ID;
   assign bus.hp0_araddr    = araddr_q;
   assign bus.hp0_arlen     = arlen_q;
   assign bus.hp0_arsize    = 3'b011;
   assign bus.hp0_arburst   = 2'b01;
   assign bus.hp0_arprot    = 3'b000;
   assign bus.hp0_arcache   = 4'b0011;
   assign bus.hp0_rready    = rready;
endmodule

// File: tb/tb_datamover_rd_ctrl.sv
// tb_datamover_rd_ctrl: scoreboard bench for datamover_rd_ctrl with an HP0 memory responder
module tb_datamover_rd_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   datamover_rd_ctrl_if bus();
   datamover_rd_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
   typedef struct {logic [63:0] d; logic l;} beat_t;
   typedef struct {logic [31:0] a; logic [3:0] len;} ar_t;
   beat_t exp_q[$];
   ar_t   ar_q[$];
   int checks = 0;
   int fails = 0;
   int ar_delay = 0;
   int err_beat = -1;
   int beat_no = 0;
   bit rand_ready = 1'b0;
   logic [22:0] cur_len = '0;
   function automatic logic [63:0] mem(input logic [31:0] a);
      return {~a, a ^ 32'h1357_9BDF};
   endfunction
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // monitor: scoreboard pops, AR compare, finish/error timing, buffer occupancy
   int occ = 0;
   bit fin_exp = 1'b0;
   bit err_exp = 1'b0;
   beat_t eb;
   ar_t ea;
   always @(negedge clk) begin
      if (!rst_n) begin
         occ = 0;
         fin_exp = 1'b0;
         err_exp = 1'b0;
      end else begin
         if (bus.o_read_finish || fin_exp) check("finish", bus.o_read_finish, fin_exp);
         fin_exp = 1'b0;
         if (bus.o_rd_cmd_ack) err_exp = 1'b0;
         if (bus.o_rd_error || err_exp) check("rd_error", bus.o_rd_error, err_exp);
         if (bus.hp0_rvalid && bus.hp0_rready && bus.hp0_rresp != 2'b00) err_exp = 1'b1;
         if (bus.hp0_arvalid && bus.hp0_arready) begin
            if (ar_q.size() == 0) check("unexpected_ar", bus.hp0_araddr, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               ea = ar_q.pop_front();
               check("araddr", bus.hp0_araddr, ea.a);
               check("arlen", bus.hp0_arlen, ea.len);
            end
         end
         if (occ == 2) check("rready_full", bus.hp0_rready, 0);
         check("valid_occ", bus.o_rd_valid, occ != 0);
         if (bus.o_rd_valid && bus.i_rd_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", bus.o_rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               eb = exp_q.pop_front();
               check("rd_data", bus.o_rd_data, eb.d);
               check("rd_last", bus.o_rd_last, eb.l);
               if (eb.l) fin_exp = 1'b1;
            end
            occ--;
         end
         if (bus.o_rd_cmd_ack && cur_len[22:3] == '0) fin_exp = 1'b1;
         if (bus.hp0_rvalid && bus.hp0_rready) occ++;
      end
   end
   // HP0 memory responder: one burst at a time, data = mem(address)
   bit ar_hs, r_hs, busy;
   int dly, s_left;
   logic [31:0] s_addr, cap_addr;
   logic [3:0] cap_len;
   initial begin
      bus.hp0_arready = 1'b0;
      bus.hp0_rvalid = 1'b0;
      bus.hp0_rdata = '0;
      bus.hp0_rresp = 2'b00;
      bus.hp0_rlast = 1'b0;
      busy = 1'b0;
      dly = 0;
      forever begin
         @(negedge clk);
         ar_hs = bus.hp0_arvalid && bus.hp0_arready;
         r_hs = bus.hp0_rvalid && bus.hp0_rready;
         cap_addr = bus.hp0_araddr;
         cap_len = bus.hp0_arlen;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            bus.hp0_arready = 1'b0;
            bus.hp0_rvalid = 1'b0;
            busy = 1'b0;
            dly = 0;
         end else begin
            if (r_hs) begin
               s_left--;
               s_addr += 32'd8;
               beat_no++;
               if (s_left == 0) begin
                  busy = 1'b0;
                  bus.hp0_rvalid = 1'b0;
               end
            end
            if (ar_hs) begin
               bus.hp0_arready = 1'b0;
               dly = 0;
               busy = 1'b1;
               s_addr = cap_addr;
               s_left = int'(cap_len) + 1;
            end else if (!busy && bus.hp0_arvalid && !bus.hp0_arready) begin
               if (dly >= ar_delay) bus.hp0_arready = 1'b1;
               else dly++;
            end
            if (busy) begin
               bus.hp0_rvalid = 1'b1;
               bus.hp0_rdata = mem(s_addr);
               bus.hp0_rlast = (s_left == 1);
               bus.hp0_rresp = (beat_no == err_beat) ? 2'b10 : 2'b00;
            end
         end
      end
   end
   initial begin
      bus.i_rd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.i_rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end
   task automatic push_ar(input logic [31:0] a, input logic [3:0] len);
      ar_t t;
      t.a = a;
      t.len = len;
      ar_q.push_back(t);
   endtask
   task automatic issue(input logic [31:0] a, input logic [22:0] len);
      beat_t b;
      int n;
      for (int i = 0; i < int'(len[22:3]); i++) begin
         b.d = mem(a + 32'(8 * i));
         b.l = (i == int'(len[22:3]) - 1);
         exp_q.push_back(b);
      end
      cur_len = len;
      @(posedge clk);
      #1;
      bus.i_rd_cmd_addr = a;
      bus.i_rd_cmd_length = len;
      bus.i_rd_cmd_req = 1'b1;
      n = 0;
      while (!bus.o_rd_cmd_ack && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ack", bus.o_rd_cmd_ack, 1);
      bus.i_rd_cmd_req = 1'b0;
      @(posedge clk);
      #1;
      check("ack_pulse", bus.o_rd_cmd_ack, 0);
   endtask
   task automatic wait_finish();
      int n = 0;
      while (!bus.o_read_finish && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("finish_seen", bus.o_read_finish, 1);
      @(posedge clk);
      #1;
      check("beats_left", exp_q.size(), 0);
      check("ars_left", ar_q.size(), 0);
   endtask
   task automatic run(input logic [31:0] a, input logic [22:0] len);
      issue(a, len);
      wait_finish();
   endtask
   task automatic check_idle_outputs(input string tag);
      check({tag, "_ack"}, bus.o_rd_cmd_ack, 0);
      check({tag, "_valid"}, bus.o_rd_valid, 0);
      check({tag, "_finish"}, bus.o_read_finish, 0);
      check({tag, "_error"}, bus.o_rd_error, 0);
      check({tag, "_arvalid"}, bus.hp0_arvalid, 0);
      check({tag, "_rready"}, bus.hp0_rready, 0);
      check({tag, "_arid"}, bus.hp0_arid, 4'h0);
      check({tag, "_arsize"}, bus.hp0_arsize, 3'b011);
      check({tag, "_arburst"}, bus.hp0_arburst, 2'b01);
      check({tag, "_arprot"}, bus.hp0_arprot, 3'b000);
      check({tag, "_arcache"}, bus.hp0_arcache, 4'b0011);
   endtask
   initial begin
      int n;
      bus.i_rd_cmd_req = 1'b0;
      bus.i_rd_cmd_addr = '0;
      bus.i_rd_cmd_length = '0;
      #1;
      check_idle_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      // single 2-beat burst
      push_ar(32'h0000_0000, 4'd1);
      run(32'h0000_0000, 23'd16);
      // full 16-beat burst
      push_ar(32'h0000_0100, 4'd15);
      run(32'h0000_0100, 23'd128);
      // 4 KB crossing split into three bursts
      push_ar(32'h0000_0FC0, 4'd7);
      push_ar(32'h0000_1000, 4'd15);
      push_ar(32'h0000_1080, 4'd7);
      run(32'h0000_0FC0, 23'd256);
      // one beat left before the page edge
      push_ar(32'h0000_1FF8, 4'd0);
      push_ar(32'h0000_2000, 4'd2);
      run(32'h0000_1FF8, 23'd32);
      // backpressure and slow arready
      rand_ready = 1'b1;
      ar_delay = 3;
      push_ar(32'h0000_2000, 4'd15);
      run(32'h0000_2000, 23'd128);
      rand_ready = 1'b0;
      ar_delay = 0;
      // SLVERR on beat 3 of 8
      err_beat = beat_no + 2;
      push_ar(32'h0000_3000, 4'd7);
      run(32'h0000_3000, 23'd64);
      check("error_sticky", bus.o_rd_error, 1);
      err_beat = -1;
      // zero length: ack clears error, no AR, finish follows
      issue(32'h0000_7000, 23'd0);
      check("error_cleared", bus.o_rd_error, 0);
      for (int i = 0; i < 3; i++) begin
         check("len0_arvalid", bus.hp0_arvalid, 0);
         @(posedge clk);
         #1;
      end
      check("len0_queues", exp_q.size() + ar_q.size(), 0);
      // asynchronous reset in the middle of a burst
      err_beat = beat_no + 1;
      push_ar(32'h0000_5000, 4'd15);
      issue(32'h0000_5000, 23'd128);
      n = 0;
      while (!bus.o_rd_error && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("error_before_reset", bus.o_rd_error, 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      exp_q.delete();
      ar_q.delete();
      err_beat = -1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_ar(32'h0000_6000, 4'd7);
      run(32'h0000_6000, 23'd64);
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: test did not complete, got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/datamover_rd_ctrl.md
Name: datamover_rd_ctrl

Overview:
MM2S read engine for the HP0 AXI3 port: accepts a read command (byte address, byte length), splits it into INCR bursts of at most 16 beats that never cross a 4 KB boundary, and issues them on the AR channel. Returned R beats pass through a 2-entry skid buffer to a valid/ready/last stream. It is the read-side counterpart of the S2MM write path in the datamover and sits between the PS HP0 port and the PL data consumer.

Parameters:
DATA_WIDTH, 64, AXI/stream data width; fixed 64 (8-byte beats)
ADDR_WIDTH, 32, AXI address width
LEN_WIDTH, 23, command byte-length width
AXI_ID, 4'h0, constant value driven on hp0_arid
MAX_BURST, 16, maximum beats per burst (AXI3 limit)

Ports:
clk  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
i_rd_cmd_addr  in  32  start byte address; must be 8-byte aligned
i_rd_cmd_length  in  23  byte count; must be a multiple of 8
i_rd_cmd_req  in  1  command request, level, held until ack
o_rd_cmd_ack  out  1  one-cycle pulse: command captured
i_rd_ready  in  1  consumer ready
o_rd_valid  out  1  stream data valid
o_rd_data  out  64  stream data
o_rd_last  out  1  final beat of the whole command
o_read_finish  out  1  one-cycle pulse: command complete
o_rd_error  out  1  sticky: a beat returned a non-OKAY rresp
hp0_arready  in  1  AR ready
hp0_arvalid  out  1  AR valid
hp0_arid  out  4  = AXI_ID
hp0_araddr  out  32  burst start address
hp0_arlen  out  4  beats-1
hp0_arsize  out  3  constant 3'b011
hp0_arburst  out  2  constant 2'b01 (INCR)
hp0_arprot  out  3  constant 3'b000
hp0_arcache  out  4  constant 4'b0011
hp0_rdata  in  64  read data
hp0_rresp  in  2  read response
hp0_rlast  in  1  last beat of burst
hp0_rvalid  in  1  R valid
hp0_rready  out  1  R ready

Behaviour:
- Reset: all outputs 0 except the constant AXI fields; the FSM returns to IDLE, the skid buffer empties, o_rd_error clears. Reset mid-burst abandons the command; outstanding R beats are not drained.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: when i_rd_cmd_req=1, capture addr/length, pulse o_rd_cmd_ack for 1 cycle, clear o_rd_error. Length 0 goes to DONE with no AR. Otherwise the FSM goes to ADDR with rem_beats = length>>3.
- ADDR: compute burst = min(16, rem_beats, (4096 - addr[11:0])>>3). Drive arvalid=1 with araddr=addr and arlen=burst-1, held stable until arready. On handshake, addr += burst*8, rem_beats -= burst, and the FSM goes to DATA. Only one burst is outstanding at a time.
- DATA: hp0_rready = skid buffer not full. Each accepted beat enters the buffer. On the beat with rlast=1: if rem_beats=0 the FSM waits for the buffer to drain and goes to DONE; otherwise it returns to ADDR.
- If rlast arrives early or late relative to arlen, this block trusts rlast for burst boundaries. The beat count is not checked.
- Any accepted beat with rresp!=2'b00 sets o_rd_error. The data is still forwarded and the command still completes.
- Skid buffer: 2 entries. o_rd_valid/o_rd_data/o_rd_last are registered. A beat transfers when o_rd_valid & i_rd_ready. Simultaneous push and pop while full is not possible because rready=0 when full. Push and pop in the same cycle with 1 entry keeps the occupancy at 1.
- o_rd_last = 1 on the beat whose global beat count equals the total for the command. It is not asserted on intermediate burst rlasts.
- DONE: pulse o_read_finish for 1 cycle, in the cycle after the o_rd_last beat transfers (or in the cycle after ack when length is 0), then go to IDLE.
- Latency: ack occurs 1 cycle after req is seen in IDLE. arvalid rises the cycle after ack. The first stream beat appears 1 cycle after the R handshake.
- i_rd_cmd_req is ignored outside IDLE.
- Address arithmetic is 32-bit and wraps at 2^32. Length bits [2:0] are ignored (truncated).

Test Plan:
1. addr 0x0, len 16, consumer always ready -> ack pulse; one AR with arlen=1, araddr=0x0; 2 beats out; o_rd_last on beat 2; o_read_finish 1 cycle later.
2. addr 0x100, len 128 -> single AR arlen=15; 16 beats in order; last only on beat 16.
3. addr 0x0FC0, len 256 -> 3 ARs: (0x0FC0, arlen 7), (0x1000, arlen 15), (0x1080, arlen 7); 32 beats total; o_rd_last only on beat 32.
4. len 128 with i_rd_ready toggling randomly and arready delayed 3 cycles -> data sequence identical to memory contents; no drop or duplication; hp0_rready=0 whenever buffer holds 2 entries.
5. rresp=2'b10 on beat 3 of 8 -> o_rd_error=1 from the next cycle; all 8 beats delivered; finish pulses; next command's ack clears o_rd_error.
6. len 0 -> ack, then finish; hp0_arvalid never asserts. Separately, rst_n low during DATA -> all outputs reset asynchronously; a new command after release runs normally.
